game_level_controller: RTL and testbench

GAME_LEVEL_CONTROLLER -- requirements
Module: game_level_controller

---
 rtl/game_level_controller.sv | 206 ++++++++++++++++++++
 tb/tb_game_level_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/game_level_controller.sv
// Game level controller: start/play/hit/level-up/win/over sequencing and obstacle motion.
// Optional macro OBS2_EN enables the second moving obstacle; otherwise obstacle 2 is fixed.
module game_level_controller #(
    parameter logic [9:0] OBS_X      = 10'd200,
    parameter logic [9:0] OBS2_X     = 10'd400,
    parameter logic [9:0] Y_MIN      = 10'd20,
    parameter logic [9:0] Y_MAX      = 10'd459,
    parameter logic [5:0] HIT_FRAMES = 6'd30,
    parameter logic [1:0] LIVES      = 2'd3
) (
    input  logic       frame_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       collision,
    input  logic       finish_line_reached,
    output logic [9:0] ObsX,
    output logic [9:0] ObsY,
    output logic [9:0] ObsX2,
    output logic [9:0] ObsY2,
    output logic [1:0] current_level,
    output logic       reset_player,
    output logic [1:0] lives,
    output logic       game_over,
    output logic       game_won,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PLAY     = 3'd1,
        HIT      = 3'd2,
        LEVEL_UP = 3'd3,
        WIN      = 3'd4,
        OVER     = 3'd5
    } state_t;

    state_t     r_state;
    logic       r_start_q;
    logic [9:0] r_obs_y;
    logic       r_dir;
    logic [1:0] r_level;
    logic [1:0] r_lives;
    logic [5:0] r_hit_cnt;
    logic       r_reset_player;
    logic       r_game_over;
    logic       r_game_won;

    state_t     w_state_nxt;
    logic       w_start_rise;
    logic [9:0] w_step;
    logic [10:0] w_mv1;
    logic [9:0] w_obs_y_nxt;
    logic       w_dir_nxt;
    logic [1:0] w_level_nxt;
    logic [1:0] w_lives_nxt;
    logic [5:0] w_hit_nxt;
    logic       w_move;
    logic       w_reload;

    // Returns {direction_down, new_y}; clamps at the bounce limits and reverses there.
    function automatic logic [10:0] move_obs(input logic [9:0] y, input logic down,
                                             input logic [9:0] step);
        logic [10:0] sum;
        sum = {1'b0, y} + {1'b0, step};
        if (down) begin
            if (sum >= {1'b0, Y_MAX})
                move_obs = {1'b0, Y_MAX};
            else
                move_obs = {1'b1, sum[9:0]};
        end else begin
            if ({1'b0, y} <= ({1'b0, Y_MIN} + {1'b0, step}))
                move_obs = {1'b1, Y_MIN};
            else
                move_obs = {1'b0, y - step};
        end
    endfunction

    assign w_start_rise = start & ~r_start_q;
    assign w_step       = 10'(r_level) + 10'd1;
    assign w_mv1        = move_obs(r_obs_y, r_dir, w_step);

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_lives_nxt = r_lives;
        w_hit_nxt   = r_hit_cnt;
        w_move      = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise)
                    w_state_nxt = PLAY;
            end
            PLAY: begin
                w_move = 1'b1;
                // Collision takes priority over reaching the finish line.
                if (collision) begin
                    w_lives_nxt = r_lives - 2'd1;
                    w_hit_nxt   = 6'd0;
                    w_state_nxt = (r_lives == 2'd1) ? OVER : HIT;
                end else if (finish_line_reached) begin
                    w_state_nxt = (r_level == 2'd3) ? WIN : LEVEL_UP;
                end
            end
            HIT: begin
                w_move = 1'b1;
                if (r_hit_cnt == HIT_FRAMES - 6'd1) begin
                    w_hit_nxt   = 6'd0;
                    w_state_nxt = PLAY;
                end else begin
                    w_hit_nxt = r_hit_cnt + 6'd1;
                end
            end
            LEVEL_UP: begin
                w_level_nxt = r_level + 2'd1;
                w_reload    = 1'b1;
                w_state_nxt = PLAY;
            end
            WIN, OVER: begin
                if (w_start_rise) begin
                    w_reload    = 1'b1;
                    w_level_nxt = 2'd0;
                    w_lives_nxt = LIVES;
                    w_hit_nxt   = 6'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_obs_y_nxt = r_obs_y;
        w_dir_nxt   = r_dir;
        if (w_reload) begin
            w_obs_y_nxt = Y_MIN;
            w_dir_nxt   = 1'b1;
        end else if (w_move) begin
            w_obs_y_nxt = w_mv1[9:0];
            w_dir_nxt   = w_mv1[10];
        end
    end

    always_ff @(posedge frame_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_start_q      <= 1'b0;
            r_obs_y        <= Y_MIN;
            r_dir          <= 1'b1;
            r_level        <= 2'd0;
            r_lives        <= LIVES;
            r_hit_cnt      <= 6'd0;
            r_reset_player <= 1'b1;
            r_game_over    <= 1'b0;
            r_game_won     <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_start_q      <= start;
            r_obs_y        <= w_obs_y_nxt;
            r_dir          <= w_dir_nxt;
            r_level        <= w_level_nxt;
            r_lives        <= w_lives_nxt;
            r_hit_cnt      <= w_hit_nxt;
            r_reset_player <= (w_state_nxt != PLAY);
            r_game_over    <= (w_state_nxt == OVER);
            r_game_won     <= (w_state_nxt == WIN);
        end
    end

`ifdef OBS2_EN
    logic [9:0]  r_obs_y2;
    logic        r_dir2;
    logic [10:0] w_mv2;

    // Obstacle 2 starts at the bottom heading up, mirroring obstacle 1.
    assign w_mv2 = move_obs(r_obs_y2, r_dir2, w_step);

    always_ff @(posedge frame_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_obs_y2 <= Y_MAX;
            r_dir2   <= 1'b0;
        end else if (w_reload) begin
            r_obs_y2 <= Y_MAX;
            r_dir2   <= 1'b0;
        end else if (w_move) begin
            r_obs_y2 <= w_mv2[9:0];
            r_dir2   <= w_mv2[10];
        end
    end

    assign ObsY2 = r_obs_y2;
`else
    assign ObsY2 = Y_MAX;
`endif

    assign ObsX          = OBS_X;
    assign ObsX2         = OBS2_X;
    assign ObsY          = r_obs_y;
    assign current_level = r_level;
    assign reset_player  = r_reset_player;
    assign lives         = r_lives;
    assign game_over     = r_game_over;
    assign game_won      = r_game_won;
    assign state         = r_state;

endmodule

// File: tb/tb_game_level_controller.sv
// Scoreboard bench for game_level_controller: stimulus queues expected frame results, a monitor checks them.
module tb_game_level_controller;

    localparam int S_IDLE = 0, S_PLAY = 1, S_HIT = 2, S_LVUP = 3, S_WIN = 4, S_OVER = 5;

    logic       frame_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       collision = 1'b0;
    logic       finish_line_reached = 1'b0;
    logic [9:0] ObsX, ObsY, ObsX2, ObsY2;
    logic [1:0] current_level;
    logic       reset_player;
    logic [1:0] lives;
    logic       game_over;
    logic       game_won;
    logic [2:0] state;

    game_level_controller dut (
        .frame_clk           (frame_clk),
        .reset_n             (reset_n),
        .start               (start),
        .collision           (collision),
        .finish_line_reached (finish_line_reached),
        .ObsX                (ObsX),
        .ObsY                (ObsY),
        .ObsX2               (ObsX2),
        .ObsY2               (ObsY2),
        .current_level       (current_level),
        .reset_player        (reset_player),
        .lives               (lives),
        .game_over           (game_over),
        .game_won            (game_won),
        .state               (state)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int cyc;
        int st;
        int oy;
        int lv;
        int lvl;
        int rp;
        int gw;
        int go;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        chk("state", int'(state), e.st);
        if (e.oy >= 0)
            chk("ObsY", int'(ObsY), e.oy);
        chk("lives", int'(lives), e.lv);
        chk("current_level", int'(current_level), e.lvl);
        chk("reset_player", int'(reset_player), e.rp);
        chk("game_won", int'(game_won), e.gw);
        chk("game_over", int'(game_over), e.go);
        chk("ObsX", int'(ObsX), 200);
        chk("ObsX2", int'(ObsX2), 400);
`ifndef OBS2_EN
        chk("ObsY2", int'(ObsY2), 459);
`endif
    endtask

    // Drive one frame of inputs and queue the state expected after the next rising edge.
    task automatic frame(input logic s, input logic c, input logic f,
                         input int st, input int oy, input int lv, input int lvl,
                         input int rp, input int gw, input int go);
        exp_t e;
        @(negedge frame_clk);
        start               = s;
        collision           = c;
        finish_line_reached = f;
        e.cyc = cyc + 1;
        e.st  = st;
        e.oy  = oy;
        e.lv  = lv;
        e.lvl = lvl;
        e.rp  = rp;
        e.gw  = gw;
        e.go  = go;
        q.push_back(e);
    endtask

    task automatic hit_wait(input int lv, input int lvl);
        for (int i = 0; i < 29; i++)
            frame(1'b0, 1'b0, 1'b0, S_HIT, -1, lv, lvl, 1, 0, 0);
        frame(1'b0, 1'b0, 1'b0, S_PLAY, -1, lv, lvl, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge frame_clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                chk("schedule", cyc, e.cyc);
                check_all(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        exp_t r;
        r.cyc = 0; r.st = S_IDLE; r.oy = 20; r.lv = 3; r.lvl = 0; r.rp = 1; r.gw = 0; r.go = 0;

        // Asynchronous reset values
        #7;
        check_all(r);
        @(negedge frame_clk);
        reset_n = 1'b1;

        frame(0, 0, 0, S_IDLE, 20, 3, 0, 1, 0, 0);
        // Held start enters PLAY once; obstacle frozen on the entry edge
        frame(1, 0, 0, S_PLAY, 20, 3, 0, 0, 0, 0);
        frame(1, 0, 0, S_PLAY, 21, 3, 0, 0, 0, 0);
        frame(1, 0, 0, S_PLAY, 22, 3, 0, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 23, 3, 0, 0, 0, 0);

        // Collision: 30 frames of HIT, collisions and start presses ignored
        frame(0, 1, 0, S_HIT, 24, 2, 0, 1, 0, 0);
        for (int i = 0; i < 29; i++)
            frame((i == 10), (i >= 3 && i <= 12), 0, S_HIT, 25 + i, 2, 0, 1, 0, 0);
        frame(0, 0, 0, S_PLAY, 54, 2, 0, 0, 0, 0);

        // Level ups at levels 0 and 1
        frame(0, 0, 1, S_LVUP, 55, 2, 0, 1, 0, 0);
        frame(0, 0, 0, S_PLAY, 20, 2, 1, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 22, 2, 1, 0, 0, 0);
        frame(0, 0, 1, S_LVUP, 24, 2, 1, 1, 0, 0);
        frame(0, 0, 0, S_PLAY, 20, 2, 2, 0, 0, 0);

        // Level 2 (step 3): bottom bounce from 458, top bounce at 21
        for (int n = 1; n <= 146; n++)
            frame(0, 0, 0, S_PLAY, 20 + 3 * n, 2, 2, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 459, 2, 2, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 456, 2, 2, 0, 0, 0);
        for (int m = 2; m <= 145; m++)
            frame(0, 0, 0, S_PLAY, 459 - 3 * m, 2, 2, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 21, 2, 2, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 20, 2, 2, 0, 0, 0);
        frame(0, 0, 0, S_PLAY, 23, 2, 2, 0, 0, 0);

        // Level 3 then WIN, restart to IDLE, second press to play
        frame(0, 0, 1, S_LVUP, 26, 2, 2, 1, 0, 0);
        frame(0, 0, 0, S_PLAY, 20, 2, 3, 0, 0, 0);
        frame(0, 0, 1, S_WIN, 24, 2, 3, 1, 1, 0);
        frame(0, 0, 0, S_WIN, 24, 2, 3, 1, 1, 0);
        frame(1, 0, 0, S_IDLE, 20, 3, 0, 1, 0, 0);
        frame(1, 0, 0, S_IDLE, 20, 3, 0, 1, 0, 0);
        frame(0, 0, 0, S_IDLE, 20, 3, 0, 1, 0, 0);
        frame(1, 0, 0, S_PLAY, 20, 3, 0, 0, 0, 0);

        // Lose lives down to 1, then collision + finish together -> OVER
        frame(0, 1, 0, S_HIT, 21, 2, 0, 1, 0, 0);
        hit_wait(2, 0);
        frame(0, 1, 0, S_HIT, -1, 1, 0, 1, 0, 0);
        hit_wait(1, 0);
        frame(0, 1, 1, S_OVER, -1, 0, 0, 1, 0, 1);
        frame(0, 0, 0, S_OVER, -1, 0, 0, 1, 0, 1);
        frame(1, 0, 0, S_IDLE, 20, 3, 0, 1, 0, 0);
        frame(0, 0, 0, S_IDLE, 20, 3, 0, 1, 0, 0);

        // Reset pulse in the middle of HIT (counter at 12)
        frame(1, 0, 0, S_PLAY, 20, 3, 0, 0, 0, 0);
        frame(0, 1, 0, S_HIT, 21, 2, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++)
            frame(0, 0, 0, S_HIT, 22 + i, 2, 0, 1, 0, 0);
        @(posedge frame_clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_all(r);
        @(negedge frame_clk);
        reset_n = 1'b1;

        // A fresh HIT must again last the full 30 frames
        frame(1, 0, 0, S_PLAY, 20, 3, 0, 0, 0, 0);
        frame(0, 1, 0, S_HIT, 21, 2, 0, 1, 0, 0);
        hit_wait(2, 0);

        for (int k = 0; k < 5 && q.size() > 0; k++)
            @(posedge frame_clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
